// File: rtl/huffman_pkg.sv
// huffman_pkg: constants and types shared by the Huffman encoder and decoder.
package huffman_pkg;

   localparam int unsigned CODE_W = 8;   // maximum code length in bits
   localparam int unsigned LEN_W  = 4;   // width of a code length field
   localparam int unsigned WORD_W = 32;  // packed link word
   localparam int unsigned BUF_W  = 64;  // decoder bit buffer
   localparam int unsigned BCNT_W = 7;   // bit buffer fill count, 0..64

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE,
      ERROR
   } state_t;

   // Mask selecting the low 'len' bits of a code.
   function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < CODE_W; b++) begin
         m[b] = (LEN_W'(b) < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/huffman_match.sv
// huffman_match: programmable codebook with a parallel compare against the
// head of the bit buffer. The lowest-index matching entry wins.
module huffman_match
   import huffman_pkg::*;
#(
   parameter int unsigned NENT  = 16,
   parameter int unsigned SYM_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     tbl_we,
   input  logic [$clog2(NENT)-1:0]  tbl_addr,
   input  logic [CODE_W-1:0]        tbl_code,
   input  logic [LEN_W-1:0]         tbl_len,
   input  logic [SYM_W-1:0]         tbl_sym,
   input  logic [CODE_W-1:0]        bits,
   input  logic [BCNT_W-1:0]        count,
   output logic                     hit,
   output logic [LEN_W-1:0]         len,
   output logic [SYM_W-1:0]         sym
);

   logic [CODE_W-1:0] code_tbl [NENT];
   logic [LEN_W-1:0]  len_tbl  [NENT];
   logic [SYM_W-1:0]  sym_tbl  [NENT];

   // Codebook storage; reset invalidates every entry by clearing its length.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NENT; i++) begin
            len_tbl[i] <= '0;
         end
      end else if (tbl_we) begin
         code_tbl[tbl_addr] <= tbl_code;
         len_tbl[tbl_addr]  <= tbl_len;
         sym_tbl[tbl_addr]  <= tbl_sym;
      end
   end

   // Parallel compare plus priority select; lengths above CODE_W are treated as invalid.
   always_comb begin
      hit = 1'b0;
      len = '0;
      sym = '0;
      for (int unsigned i = 0; i < NENT; i++) begin
         if (!hit
             && (len_tbl[i] != '0)
             && (len_tbl[i] <= LEN_W'(CODE_W))
             && (BCNT_W'(len_tbl[i]) <= count)
             && (((bits ^ code_tbl[i]) & len_mask(len_tbl[i])) == '0)) begin
            hit = 1'b1;
            len = len_tbl[i];
            sym = sym_tbl[i];
         end
      end
   end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: unpacks LSB-first 32-bit words into a 64-bit bit buffer and
// emits one decoded symbol per cycle through a single-entry output register.
module huffman_decoder
   import huffman_pkg::*;
#(
   parameter int unsigned NENT  = 16,
   parameter int unsigned SYM_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     tbl_we,
   input  logic [$clog2(NENT)-1:0]  tbl_addr,
   input  logic [CODE_W-1:0]        tbl_code,
   input  logic [LEN_W-1:0]         tbl_len,
   input  logic [SYM_W-1:0]         tbl_sym,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_symbols,
   input  logic [WORD_W-1:0]        in_word,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [SYM_W-1:0]         sym_out,
   output logic                     sym_valid,
   input  logic                     sym_ready,
   output logic                     done,
   output logic                     error
);

   state_t            state, state_next;
   logic [BUF_W-1:0]  bbuf, buf_next, buf_shift;
   logic [BCNT_W-1:0] bcnt, cnt_next, cnt_left, consume;
   logic [CNT_W-1:0]  sym_cnt, sym_total;

   logic              hit;
   logic [LEN_W-1:0]  mlen;
   logic [SYM_W-1:0]  msym;

   logic tbl_wr, frame_open, slot_free, load, no_match, accept, last_out, begin_frame;

   assign tbl_wr      = tbl_we && (state == IDLE);
   assign frame_open  = (state == RUN) && (sym_cnt != sym_total);
   assign slot_free   = !sym_valid || sym_ready;
   assign load        = frame_open && hit && slot_free;
   assign no_match    = frame_open && !hit && (bcnt >= BCNT_W'(CODE_W));
   assign accept      = in_valid && in_ready;
   assign last_out    = (state == RUN) && (sym_cnt == sym_total) && sym_valid && sym_ready;
   assign begin_frame = start && ((state == IDLE) || (state == DONE));

   huffman_match #(
      .NENT  (NENT),
      .SYM_W (SYM_W)
   ) u_match (
      .clock    (clock),
      .reset    (reset),
      .tbl_we   (tbl_wr),
      .tbl_addr (tbl_addr),
      .tbl_code (tbl_code),
      .tbl_len  (tbl_len),
      .tbl_sym  (tbl_sym),
      .bits     (bbuf[CODE_W-1:0]),
      .count    (bcnt),
      .hit      (hit),
      .len      (mlen),
      .sym      (msym)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; ERROR is left only through reset.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = (num_symbols == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_out) begin
               state_next = DONE;
            end else if (no_match) begin
               state_next = ERROR;
            end
         end
         ERROR:   state_next = ERROR;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      in_ready = (state == RUN) && (bcnt <= BCNT_W'(WORD_W));
      done     = (state == DONE);
      error    = (state == ERROR);
   end

   // Bit buffer update: consume the matched code and append an accepted word in the same cycle.
   always_comb begin
      consume   = load ? BCNT_W'(mlen) : '0;
      cnt_left  = bcnt - consume;
      buf_shift = bbuf >> consume;
      buf_next  = buf_shift;
      cnt_next  = cnt_left;
      if (begin_frame) begin
         buf_next = '0;
         cnt_next = '0;
      end else if (accept) begin
         // New word lands directly above the bits that survive this cycle's consume.
         buf_next = buf_shift | (BUF_W'(in_word) << cnt_left);
         cnt_next = cnt_left + BCNT_W'(WORD_W);
      end
   end

   // Buffer, symbol counter and output slot registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         bbuf      <= '0;
         bcnt      <= '0;
         sym_cnt   <= '0;
         sym_total <= '0;
         sym_out   <= '0;
         sym_valid <= 1'b0;
      end else begin
         bbuf <= buf_next;
         bcnt <= cnt_next;
         if (begin_frame) begin
            sym_cnt   <= '0;
            sym_total <= num_symbols;
         end else if (load) begin
            sym_cnt <= sym_cnt + CNT_W'(1);
         end
         if (load) begin
            sym_out   <= msym;
            sym_valid <= 1'b1;
         end else if (sym_ready) begin
            sym_valid <= 1'b0;
         end
      end
   end

endmodule
